keymgr_sideload_streamer: RTL and testbench

KEYMGR_SIDELOAD_STREAMER -- requirements
Module: keymgr_sideload_streamer

---
 rtl/keymgr_pkg.sv | 23 ++
 rtl/keymgr_sideload_streamer_if.sv | 28 ++
 rtl/keymgr_word_cnt.sv | 62 ++++++
 rtl/keymgr_sideload_streamer.sv | 144 ++++++++++++++
 tb/tb_keymgr_sideload_streamer.sv | 276 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/keymgr_pkg.sv
// keymgr_pkg: shared definitions for the key sideload streamer.
//   - default share count / key width / word width
//   - FSM state encoding
//   - counter width helper (clog2 with a floor of 1 bit)
package keymgr_pkg;

    localparam int DefaultNumSharesKey = 2;
    localparam int DefaultKeyWidth     = 256;
    localparam int DefaultWordWidth    = 32;

    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StStream = 2'd1,
        StHold   = 2'd2,
        StWipe   = 2'd3
    } state_e;

    // Width of a counter that indexes n items; never narrower than 1 bit.
    function automatic int cnt_width(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/keymgr_sideload_streamer_if.sv
// keymgr_sideload_streamer_if: word stream from the streamer to its consumer.
//   word_o        streamed key word
//   word_share_o  share index of word_o
//   word_idx_o    word index within the share
//   word_valid_o  word_o valid
//   word_ready_i  consumer accepts the word
// Signal names keep the streamer's point of view (master drives *_o).
interface keymgr_sideload_streamer_if #(
    parameter int WordWidth = 32,
    parameter int ShareW    = 1,
    parameter int IdxW      = 3
);
    logic [WordWidth-1:0] word_o;
    logic [ShareW-1:0]    word_share_o;
    logic [IdxW-1:0]      word_idx_o;
    logic                 word_valid_o;
    logic                 word_ready_i;

    modport master (
        output word_o, word_share_o, word_idx_o, word_valid_o,
        input  word_ready_i
    );

    modport slave (
        input  word_o, word_share_o, word_idx_o, word_valid_o,
        output word_ready_i
    );
endinterface

// File: rtl/keymgr_word_cnt.sv
// keymgr_word_cnt: share/word position counter for the key stream.
//   clk_i, rst_i  clock, synchronous active-high reset
//   clr_i         return to (share 0, word 0)
//   inc_i         advance one word; wraps word index into the next share
//   share_o       current share index
//   idx_o         current word index within the share
//   last_o        position is the final word of the final share
module keymgr_word_cnt
    import keymgr_pkg::*;
#(
    parameter  int NumShares = 2,
    parameter  int NumRegs   = 8,
    localparam int ShareW    = cnt_width(NumShares),
    localparam int IdxW      = cnt_width(NumRegs)
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              clr_i,
    input  logic              inc_i,
    output logic [ShareW-1:0] share_o,
    output logic [IdxW-1:0]   idx_o,
    output logic              last_o
);

    logic [ShareW-1:0] share_q, share_d;
    logic [IdxW-1:0]   idx_q, idx_d;
    logic              idx_wrap;

    assign idx_wrap = (idx_q == IdxW'(NumRegs - 1));
    assign last_o   = idx_wrap && (share_q == ShareW'(NumShares - 1));
    assign share_o  = share_q;
    assign idx_o    = idx_q;

    always_comb begin
        share_d = share_q;
        idx_d   = idx_q;
        if (clr_i) begin
            share_d = '0;
            idx_d   = '0;
        end else if (inc_i) begin
            if (idx_wrap) begin
                idx_d   = '0;
                // Wrap fully after the last word so the counter never
                // holds an out-of-range share index.
                share_d = last_o ? '0 : share_q + 1'b1;
            end else begin
                idx_d = idx_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            share_q <= '0;
            idx_q   <= '0;
        end else begin
            share_q <= share_d;
            idx_q   <= idx_d;
        end
    end

endmodule

// File: rtl/keymgr_sideload_streamer.sv
// keymgr_sideload_streamer: captures a multi-share key on the rising edge of
// key_valid_i, streams it word by word over a valid/ready interface, then
// presents it as a parallel sideload view until the request drops or a clear
// arrives, after which the key is wiped.
//   clk_i, rst_i      clock, synchronous active-high reset
//   key_valid_i       key request (level); rising edge captures key_i
//   key_i             key shares
//   clear_i           wipe request, overrides everything
//   word_if           word stream (master side)
//   key_sideload_o    parallel register view, valid in HOLD only
//   sideload_valid_o  key_sideload_o valid
//   busy_o            FSM not idle
module keymgr_sideload_streamer
    import keymgr_pkg::*;
#(
    parameter  int NumSharesKey = DefaultNumSharesKey,
    parameter  int KeyWidth     = DefaultKeyWidth,
    parameter  int WordWidth    = DefaultWordWidth,
    localparam int NumRegsKey   = KeyWidth / WordWidth,
    localparam int ShareW       = cnt_width(NumSharesKey),
    localparam int IdxW         = cnt_width(NumRegsKey)
) (
    input  logic                                    clk_i,
    input  logic                                    rst_i,
    input  logic                                    key_valid_i,
    input  logic [NumSharesKey-1:0][KeyWidth-1:0]   key_i,
    input  logic                                    clear_i,
    keymgr_sideload_streamer_if.master              word_if,
    output logic [NumRegsKey-1:0][WordWidth-1:0]    key_sideload_o [NumSharesKey-1:0],
    output logic                                    sideload_valid_o,
    output logic                                    busy_o
);

    if ((KeyWidth % WordWidth) != 0 || NumSharesKey < 1) begin : g_param_err
        $error("keymgr_sideload_streamer: KeyWidth must be a multiple of WordWidth and NumSharesKey >= 1");
    end

    state_e                                 state_q, state_d;
    logic [NumSharesKey-1:0][KeyWidth-1:0]  key_q, key_d;
    logic                                   key_valid_q;
    logic                                   capture;
    logic                                   stream_act;
    logic                                   hold_act;
    logic                                   handshake;
    logic                                   cnt_clr, cnt_inc, cnt_last;
    logic [ShareW-1:0]                      cnt_share;
    logic [IdxW-1:0]                        cnt_idx;

    keymgr_word_cnt #(
        .NumShares (NumSharesKey),
        .NumRegs   (NumRegsKey)
    ) u_word_cnt (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .clr_i   (cnt_clr),
        .inc_i   (cnt_inc),
        .share_o (cnt_share),
        .idx_o   (cnt_idx),
        .last_o  (cnt_last)
    );

    assign capture    = key_valid_i & ~key_valid_q;
    // Outputs are gated by rst_i so they read zero throughout reset.
    assign stream_act = (state_q == StStream) & ~rst_i;
    assign hold_act   = (state_q == StHold) & ~rst_i;
    assign handshake  = stream_act & word_if.word_ready_i;

    always_comb begin
        state_d = state_q;
        key_d   = key_q;
        cnt_clr = 1'b0;
        cnt_inc = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (capture) begin
                    key_d   = key_i;
                    cnt_clr = 1'b1;
                    state_d = StStream;
                end
            end
            StStream: begin
                if (!key_valid_i) begin
                    state_d = StWipe;
                end else if (handshake) begin
                    cnt_inc = 1'b1;
                    if (cnt_last) state_d = StHold;
                end
            end
            StHold: begin
                if (!key_valid_i) state_d = StWipe;
            end
            StWipe: begin
                key_d   = '0;
                cnt_clr = 1'b1;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
        // Clear beats a same-cycle capture and discards the key right away.
        if (clear_i) begin
            state_d = StWipe;
            key_d   = '0;
            cnt_clr = 1'b1;
            cnt_inc = 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= StIdle;
            key_q       <= '0;
            key_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            key_q       <= key_d;
            key_valid_q <= key_valid_i;
        end
    end

    always_comb begin
        word_if.word_valid_o = 1'b0;
        word_if.word_o       = '0;
        word_if.word_share_o = '0;
        word_if.word_idx_o   = '0;
        if (stream_act) begin
            word_if.word_valid_o = 1'b1;
            word_if.word_o       = key_q[cnt_share][cnt_idx*WordWidth +: WordWidth];
            word_if.word_share_o = cnt_share;
            word_if.word_idx_o   = cnt_idx;
        end
    end

    always_comb begin
        for (int s = 0; s < NumSharesKey; s++) begin
            for (int i = 0; i < NumRegsKey; i++) begin
                key_sideload_o[s][i] = hold_act ? key_q[s][i*WordWidth +: WordWidth] : '0;
            end
        end
    end

    assign sideload_valid_o = hold_act;
    assign busy_o           = ~rst_i & (state_q != StIdle);

endmodule

// File: tb/tb_keymgr_sideload_streamer.sv
module tb_keymgr_sideload_streamer;

    typedef struct {
        bit rst, kv, clr, rdy;
        bit wv, busy, slv;
        logic [31:0] word;
    } vec_t;

    typedef struct {
        logic [31:0] w;
        logic [0:0]  s;
        logic [2:0]  i;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    // default build: 2 shares x 8 words
    logic                 kv = 1'b0, clr = 1'b0;
    logic [1:0][255:0]    key = '0;
    logic [7:0][31:0]     ksl [1:0];
    logic                 slv, busy;
    keymgr_sideload_streamer_if #(.WordWidth(32), .ShareW(1), .IdxW(3)) wif();

    keymgr_sideload_streamer #(.NumSharesKey(2), .KeyWidth(256), .WordWidth(32)) dut (
        .clk_i(clk), .rst_i(rst), .key_valid_i(kv), .key_i(key), .clear_i(clr),
        .word_if(wif), .key_sideload_o(ksl), .sideload_valid_o(slv), .busy_o(busy)
    );

    // 3 shares x 4 words build
    logic                 kv2 = 1'b0, clr2 = 1'b0;
    logic [2:0][127:0]    key2 = '0;
    logic [3:0][31:0]     ksl2 [2:0];
    logic                 slv2, busy2;
    keymgr_sideload_streamer_if #(.WordWidth(32), .ShareW(2), .IdxW(2)) wif2();

    keymgr_sideload_streamer #(.NumSharesKey(3), .KeyWidth(128), .WordWidth(32)) dut2 (
        .clk_i(clk), .rst_i(rst), .key_valid_i(kv2), .key_i(key2), .clear_i(clr2),
        .word_if(wif2), .key_sideload_o(ksl2), .sideload_valid_o(slv2), .busy_o(busy2)
    );

    int   n_vec = 0, n_err = 0;
    exp_t sb[$];
    vec_t tbl[10];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic new_key;
        for (int s = 0; s < 2; s++)
            for (int i = 0; i < 8; i++)
                key[s][i*32 +: 32] = $urandom;
    endtask

    task automatic push_key;
        exp_t e;
        for (int s = 0; s < 2; s++)
            for (int i = 0; i < 8; i++) begin
                e.w = key[s][i*32 +: 32];
                e.s = s[0:0];
                e.i = i[2:0];
                sb.push_back(e);
            end
    endtask

    // scoreboard monitor: pop on each handshake, hold check on stalls
    bit          mon_en = 1'b0;
    bit          stall  = 1'b0;
    logic [35:0] stall_v;
    exp_t        e_mon;
    always @(negedge clk) begin
        if (mon_en && wif.word_valid_o) begin
            if (stall)
                chk("stall_stable", {wif.word_o, wif.word_share_o, wif.word_idx_o}, stall_v);
            if (wif.word_ready_i) begin
                if (sb.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL sb_underflow: got word %h with no expected entry", wif.word_o);
                end else begin
                    e_mon = sb.pop_front();
                    chk("stream_word", {wif.word_o, wif.word_share_o, wif.word_idx_o},
                        {e_mon.w, e_mon.s, e_mon.i});
                end
                stall = 1'b0;
            end else begin
                stall   = 1'b1;
                stall_v = {wif.word_o, wif.word_share_o, wif.word_idx_o};
            end
        end else begin
            stall = 1'b0;
        end
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not reach the end");
        $fatal(1, "timeout");
    end

    initial begin
        int hs, cyc, cnt, n, c;
        logic [31:0] acc;

        // ---------- table: reset, clear vs capture, edge capture, clear abort
        //                rst kv clr rdy wv busy slv word
        tbl[0] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0};
        tbl[1] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0};
        tbl[2] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0};  // clear beats capture
        tbl[3] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0};  // WIPE -> IDLE
        tbl[4] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0};  // held high: no capture
        tbl[5] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0};
        tbl[6] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 32'hA5A5_0001};
        tbl[7] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 32'hA5A5_0001};
        tbl[8] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0};  // clear mid-stream
        tbl[9] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0};
        key[0][31:0] = 32'hA5A5_0001;
        wif.word_ready_i  = 1'b0;
        wif2.word_ready_i = 1'b0;

        for (int r = 0; r < 10; r++) begin
            rst = tbl[r].rst; kv = tbl[r].kv; clr = tbl[r].clr;
            wif.word_ready_i = tbl[r].rdy;
            tick();
            chk($sformatf("tbl%0d_valid", r), wif.word_valid_o, tbl[r].wv);
            chk($sformatf("tbl%0d_busy", r), busy, tbl[r].busy);
            chk($sformatf("tbl%0d_slv", r), slv, tbl[r].slv);
            chk($sformatf("tbl%0d_word", r), wif.word_o, tbl[r].word);
        end

        // ---------- full stream at ready=1, then HOLD view, then clear in HOLD
        kv = 1'b0; clr = 1'b0; tick();
        new_key();
        key[0][31:0] = 32'h0;
        key[0][255]  = 1'b1;
        push_key();
        mon_en = 1'b1;
        kv = 1'b1; wif.word_ready_i = 1'b1;
        tick();
        for (int k = 0; k < 16; k++) begin
            chk("s1_valid", wif.word_valid_o, 1'b1);
            tick();
        end
        chk("s1_hold_slv", slv, 1'b1);
        chk("s1_hold_wv", wif.word_valid_o, 1'b0);
        chk("s1_hold_word", wif.word_o, 32'h0);
        chk("s1_hold_busy", busy, 1'b1);
        chk("s1_sb_empty", sb.size(), 0);
        for (int s = 0; s < 2; s++)
            for (int i = 0; i < 8; i++)
                chk($sformatf("s1_sideload_%0d_%0d", s, i), ksl[s][i], key[s][i*32 +: 32]);
        clr = 1'b1; tick();
        acc = '0;
        for (int s = 0; s < 2; s++)
            for (int i = 0; i < 8; i++) acc = acc | ksl[s][i];
        chk("clr_hold_slv", slv, 1'b0);
        chk("clr_hold_sideload", acc, 32'h0);
        chk("clr_hold_busy", busy, 1'b1);
        clr = 1'b0; tick();
        chk("clr_idle_busy", busy, 1'b0);
        tick();
        chk("no_recapture_busy", busy, 1'b0);
        chk("no_recapture_wv", wif.word_valid_o, 1'b0);

        // ---------- ready toggling, key_i changes after capture
        kv = 1'b0; tick();
        new_key();
        push_key();
        kv = 1'b1; tick();
        key[0] = ~key[0];
        key[1] = ~key[1];
        hs = 0; cyc = 0; c = 0;
        while (!slv && c < 100) begin
            wif.word_ready_i = (c % 2 == 0);
            if (wif.word_valid_o && wif.word_ready_i) hs++;
            if (wif.word_valid_o) cyc++;
            c++;
            tick();
        end
        chk("toggle_handshakes", hs, 16);
        chk("toggle_cycles", cyc, 31);
        chk("toggle_sb_empty", sb.size(), 0);

        // ---------- held through HOLD, drop, re-rise: exactly one new stream
        wif.word_ready_i = 1'b1;
        tick(); tick();
        chk("held_hold_slv", slv, 1'b1);
        kv = 1'b0; tick(); tick();
        push_key();
        kv = 1'b1;
        cnt = 0;
        for (int k = 0; k < 40; k++) begin
            tick();
            if (wif.word_valid_o) cnt++;
        end
        chk("rerise_word_count", cnt, 16);
        chk("rerise_slv", slv, 1'b1);
        chk("rerise_sb_empty", sb.size(), 0);

        // ---------- abort after 5 handshakes
        kv = 1'b0; tick(); tick();
        new_key();
        push_key();
        kv = 1'b1; wif.word_ready_i = 1'b1;
        tick();
        for (int k = 0; k < 5; k++) tick();
        kv = 1'b0; wif.word_ready_i = 1'b0;
        chk("abort_pre_wv", wif.word_valid_o, 1'b1);
        tick();
        chk("abort_wv", wif.word_valid_o, 1'b0);
        chk("abort_word", wif.word_o, 32'h0);
        chk("abort_wipe_busy", busy, 1'b1);
        tick();
        chk("abort_idle_busy", busy, 1'b0);
        chk("abort_keyq_zero", {63'd0, |dut.key_q}, 64'd0);
        chk("abort_sb_left", sb.size(), 11);
        sb.delete();

        // ---------- reset mid-stream
        tick();
        new_key();
        push_key();
        kv = 1'b1; wif.word_ready_i = 1'b1;
        tick();
        for (int k = 0; k < 3; k++) tick();
        rst = 1'b1; kv = 1'b0;
        tick();
        chk("rst_wv", wif.word_valid_o, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_slv", slv, 1'b0);
        chk("rst_word", {wif.word_o, wif.word_share_o, wif.word_idx_o}, 36'h0);
        rst = 1'b0;
        tick();
        chk("post_rst_wv", wif.word_valid_o, 1'b0);
        tick();
        chk("post_rst_wv2", wif.word_valid_o, 1'b0);
        chk("rst_sb_left", sb.size(), 13);
        sb.delete();
        mon_en = 1'b0;

        // ---------- 3 shares x 128-bit build streams 12 words
        for (int s = 0; s < 3; s++)
            for (int i = 0; i < 4; i++)
                key2[s][i*32 +: 32] = $urandom;
        wif2.word_ready_i = 1'b1;
        kv2 = 1'b1;
        tick();
        n = 0; c = 0;
        while (!slv2 && c < 50) begin
            if (wif2.word_valid_o) begin
                chk("w3_word", {wif2.word_o, wif2.word_share_o, wif2.word_idx_o},
                    {key2[n/4][(n%4)*32 +: 32], 2'(n/4), 2'(n%4)});
                n++;
            end
            c++;
            tick();
        end
        chk("w3_word_count", n, 12);
        chk("w3_slv", slv2, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
